// File: rtl/sum_bist_pkg.sv
// sum_bist shared types and constants.
// Expected result of vector i is 2i+1; callers truncate to WIDTH.
package sum_bist_pkg;

    localparam int SUM_BIST_WIDTH   = 8;
    localparam int SUM_BIST_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DRAIN,
        DONE
    } sum_bist_state_t;

    function automatic logic [31:0] sum_bist_exp(input logic [31:0] i);
        return (i << 1) + 32'd1;
    endfunction

endpackage

// File: rtl/sum_bist_if.sv
// Operand/result bundle between sum_bist and the adder under test.
// master = stimulus side, slave = adder side.
interface sum_bist_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;

    modport master (output a, output b, input c);
    modport slave  (input a, input b, output c);
endinterface

// File: rtl/sum_bist_delay.sv
// LATENCY-stage {valid, exp} shift register for the compare pipeline.
// clr drops in-flight entries while stage 0 still takes the new launch.
module sum_bist_delay #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             clr,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_exp,
    output logic             out_v,
    output logic [WIDTH-1:0] out_exp
);

    logic [LATENCY-1:0]            vld;
    logic [LATENCY-1:0][WIDTH-1:0] ex;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld <= '0;
            ex  <= '0;
        end else begin
            vld[0] <= in_v;
            ex[0]  <= in_exp;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= clr ? 1'b0 : vld[i-1];
                ex[i]  <= clr ? '0 : ex[i-1];
            end
        end
    end

    assign out_v   = vld[LATENCY-1];
    assign out_exp = ex[LATENCY-1];

endmodule

// File: rtl/sum_bist.sv
// Stimulus/response BIST for the registered sum adder.
// SUM_BIST_FIRST_ERR_EN adds first-mismatch capture outputs.
module sum_bist
    import sum_bist_pkg::*;
#(
    parameter int WIDTH       = SUM_BIST_WIDTH,
    parameter int LATENCY     = SUM_BIST_LATENCY,
    parameter int NUM_VECTORS = 6,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             start,
    sum_bist_if.master       bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef SUM_BIST_FIRST_ERR_EN
    ,
    output logic [WIDTH-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
`endif
);

    localparam int CW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    sum_bist_state_t  state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    vec;
    logic [DW-1:0]    dcnt;
    logic             go;
    logic             launch;
    logic             last;
    logic             due;
    logic             miss;
    logic [ERR_W-1:0] err_nxt;
    logic [WIDTH-1:0] vec_exp;
    logic             dly_v;
    logic [WIDTH-1:0] dly_exp;

    always_comb begin
        go      = start && (state == IDLE || state == DONE);
        launch  = go || (state == DRIVE);
        vec     = go ? '0 : cnt;
        last    = (vec == CW'(NUM_VECTORS - 1));
        vec_exp = WIDTH'(sum_bist_exp(32'(vec)));
        due     = dly_v && !go;
        // case-inequality: any X/Z on a due result is a miss
        miss    = due && (bus.c !== dly_exp);
        err_nxt = err_count;
        if (go)
            err_nxt = '0;
        else if (miss && err_count != '1)
            err_nxt = err_count + ERR_W'(1);
    end

    sum_bist_delay #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_dly (
        .clk     (clk),
        .aresetn (aresetn),
        .clr     (go),
        .in_v    (launch),
        .in_exp  (vec_exp),
        .out_v   (dly_v),
        .out_exp (dly_exp)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            bus.a     <= '0;
            bus.b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
        end else begin
            err_count <= err_nxt;
            if (launch) begin
                bus.a <= WIDTH'(vec);
                bus.b <= WIDTH'(32'(vec) + 1);
                cnt   <= CW'(32'(vec) + 1);
            end
            unique case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state <= last ? DRAIN : DRIVE;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                        dcnt  <= '0;
                    end
                end
                DRIVE: begin
                    if (last) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    // the last compare lands LATENCY edges after the last launch
                    if (dcnt == DW'(LATENCY - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SUM_BIST_FIRST_ERR_EN
    logic [WIDTH-1:0] cmp_idx;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cmp_idx       <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (go) begin
            cmp_idx       <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (due) begin
            cmp_idx <= cmp_idx + WIDTH'(1);
            if (miss && err_count == '0) begin
                first_err_idx <= cmp_idx;
                first_err_exp <= dly_exp;
                first_err_got <= bus.c;
            end
        end
    end
`endif

endmodule
